// File: rtl/wave_voice_sched_if.sv
// rtl/wave_voice_sched_if.sv - wavetable ROM read port shared by the voice scheduler
// rom_data is registered in the ROM: it is valid the cycle after rom_rd.
interface wave_voice_sched_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [DW-1:0] rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/wave_voice_sched.sv
// rtl/wave_voice_sched.sv - time-shares one wavetable ROM among up to eight tone voices per sample tick
// Optional WAVE_SCHED_OVERRUN_EN adds a sticky tick-while-busy flag.
module wave_voice_sched #(
    parameter int VOICES = 4,
    parameter int DEPTH  = 50,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int MW     = DW + $clog2(VOICES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sample_tick_i,
    input  logic [VOICES-1:0]      voice_en_i,
    input  logic [VOICES*AW-1:0]   voice_step_i,
    wave_voice_sched_if.master     rom,
    output logic [MW-1:0]          mix_out_o,
    output logic                   mix_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o
);
    localparam int CW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;

    state_e              state_q, state_d;
    logic [VOICES-1:0]   pending_q, pending_d;
    logic [CW-1:0]       cur_q, cur_d;
    logic [CW-1:0]       lowest;
    logic [MW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       index_q [VOICES];
    logic [AW-1:0]       index_d [VOICES];
    logic [MW-1:0]       mix_q;
    logic                mix_valid_q;
    logic [AW-1:0]       step_raw;
    logic [AW-1:0]       step_sat;
    logic [AW:0]         step_sum;
    logic [AW:0]         step_wrap;

    always_comb begin
        lowest = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (pending_q[v]) lowest = CW'(v);
        end
    end

    // Index advance uses one extra bit so a single conditional subtract wraps any legal sum.
    always_comb begin
        step_raw  = voice_step_i[int'(cur_q)*AW +: AW];
        step_sat  = ({1'b0, step_raw} >= (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : step_raw;
        step_sum  = {1'b0, index_q[cur_q]} + {1'b0, step_sat};
        step_wrap = (step_sum >= (AW+1)'(DEPTH)) ? step_sum - (AW+1)'(DEPTH) : step_sum;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cur_d     = cur_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        index_d   = index_q;
        case (state_q)
            IDLE: begin
                for (int v = 0; v < VOICES; v++) begin
                    if (!voice_en_i[v]) index_d[v] = '0;
                end
                if (sample_tick_i) begin
                    pending_d = voice_en_i;
                    acc_d     = '0;
                    state_d   = (|voice_en_i) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                cur_d             = lowest;
                addr_d            = index_q[lowest];
                pending_d[lowest] = 1'b0;
                state_d           = CAPTURE;
            end
            CAPTURE: begin
                acc_d          = acc_q + MW'(rom.rom_data);
                index_d[cur_q] = step_wrap[AW-1:0];
                state_d        = (|pending_q) ? ISSUE : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cur_q       <= '0;
            acc_q       <= '0;
            addr_q      <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            for (int v = 0; v < VOICES; v++) index_q[v] <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_q       <= cur_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            mix_valid_q <= (state_q == DONE);
            if (state_q == DONE) mix_q <= acc_q;
        end
    end

    // Address is presented combinationally in ISSUE so the registered ROM returns data in CAPTURE.
    assign rom.rom_addr = (state_q == ISSUE) ? index_q[lowest] : addr_q;
    assign rom.rom_rd   = (state_q == ISSUE);
    assign mix_out_o    = mix_q;
    assign mix_valid_o  = mix_valid_q;
    assign busy_o       = (state_q != IDLE);

`ifdef WAVE_SCHED_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)                                   overrun_q <= 1'b0;
        else if (sample_tick_i && state_q != IDLE)   overrun_q <= 1'b1;
    end
    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif
endmodule
